// File: rtl/speed_disp_pkg.sv
// Shared display definitions: blank/saturation codes, speed limit, FSM states.
// Used by the speed formatter and by the segment decoder for its blank code.
package speed_disp_pkg;

  localparam logic [7:0] BLANK_MSG = 8'hFF;
  localparam logic [7:0] SAT_MSG   = 8'h99;
  localparam logic [7:0] MAX_SPEED = 8'd99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    NOTIFY = 2'd2
  } dispState_e;

endpackage

// File: rtl/speed_bcd_formatter_if.sv
// Speed formatter bus: sample/peak controls in, BCD message and status out.
// master drives samples (speed source); slave is the formatter.
interface speed_bcd_formatter_if;

  logic [7:0] speed_bin;
  logic       speed_valid;
  logic       peak_mode;
  logic       peak_clr;
  logic [7:0] msg;
  logic       noti;
  logic       busy;
  logic       ovf;

  modport master (
    output speed_bin, speed_valid, peak_mode, peak_clr,
    input  msg, noti, busy, ovf
  );

  modport slave (
    input  speed_bin, speed_valid, peak_mode, peak_clr,
    output msg, noti, busy, ovf
  );

endinterface

// File: rtl/speed_bcd_formatter_bin2bcd_seq.sv
// Sequential double-dabble: start loads a 7b value, 8 add-3/shift steps follow.
// Ports: clk, rst_n, start, bin[6:0] in; done (held until next start), bcd[7:0] out.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [7:0] bcd
);

  logic [15:0] sr;
  logic [15:0] adj;
  logic [3:0]  cnt;
  logic        active;

  always_comb begin
    adj = sr;
    if (sr[11:8] >= 4'd5)
      adj[11:8] = sr[11:8] + 4'd3;
    if (sr[15:12] >= 4'd5)
      adj[15:12] = sr[15:12] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr     <= {9'd0, bin};
      cnt    <= '0;
      active <= 1'b1;
    end else if (active && cnt != 4'd8) begin
      sr  <= adj << 1;
      cnt <= cnt + 4'd1;
    end
  end

  assign done = active && (cnt == 4'd8);
  assign bcd  = sr[15:8];

endmodule

// File: rtl/speed_bcd_formatter.sv
// Speed sample to 2-digit BCD display message with saturation, peak-hold,
// newest-wins pending slot and blank-on-timeout. Ports: clk, rst_n, bus (slave).
module speed_bcd_formatter
  import speed_disp_pkg::*;
#(
  parameter int NOTI_CYCLES    = 50,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  speed_bcd_formatter_if.slave bus
);

  localparam int NW = (NOTI_CYCLES > 1) ? $clog2(NOTI_CYCLES) : 1;

  dispState_e state, stateNext;

  logic [7:0]    msgQ;
  logic          ovfQ;
  logic          ovfPend;
  logic [7:0]    pend;
  logic          pendValid;
  logic [7:0]    peak;
  logic [TO_W-1:0] toCnt;
  logic [NW-1:0] notiCnt;

  logic [7:0] cand;
  logic       candValid;
  logic [7:0] effPeak;
  logic       dropPeak;
  logic       isIdle;
  logic       accept;
  logic       toHit;
  logic       sat;
  logic [6:0] convIn;
  logic       convDone;
  logic [7:0] convBcd;
  logic       notiLast;

  // A live sample overrides a stale pending one (newest wins).
  always_comb begin
    cand      = bus.speed_valid ? bus.speed_bin : pend;
    candValid = bus.speed_valid | pendValid;
    effPeak   = bus.peak_clr ? 8'd0 : peak;
    dropPeak  = bus.peak_mode && (cand <= effPeak);
    isIdle    = (state == IDLE);
    accept    = isIdle && candValid && !dropPeak;
    toHit     = isIdle && !candValid &&
                (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
    sat       = cand > MAX_SPEED;
    convIn    = sat ? 7'd0 : cand[6:0];
    notiLast  = (notiCnt == NW'(NOTI_CYCLES - 1));
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (convIn),
    .done  (convDone),
    .bcd   (convBcd)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (accept)
          stateNext = CONV;
        else if (toHit)
          stateNext = NOTIFY;
      end
      CONV: begin
        if (convDone)
          stateNext = NOTIFY;
      end
      NOTIFY: begin
        if (notiLast)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      notiCnt <= '0;
    end else if (state == NOTIFY) begin
      notiCnt <= notiCnt + NW'(1);
    end else begin
      notiCnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msgQ    <= BLANK_MSG;
      ovfQ    <= 1'b0;
      ovfPend <= 1'b0;
    end else begin
      if (accept)
        ovfPend <= sat;
      if (state == CONV && convDone) begin
        msgQ <= ovfPend ? SAT_MSG : convBcd;
        ovfQ <= ovfPend;
      end else if (toHit) begin
        msgQ <= BLANK_MSG;
        ovfQ <= 1'b0;
      end
    end
  end

  // Pending slot: loaded while busy, drained on any IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pendValid <= 1'b0;
    end else if (!isIdle) begin
      if (bus.speed_valid) begin
        pend      <= bus.speed_bin;
        pendValid <= 1'b1;
      end
    end else begin
      pendValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      peak <= '0;
    else if (accept && bus.peak_mode)
      peak <= cand;
    else if (bus.peak_clr)
      peak <= '0;
  end

  // Counter saturates at TIMEOUT_CYCLES so blanking fires once per silence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      toCnt <= '0;
    else if (bus.speed_valid)
      toCnt <= '0;
    else if (isIdle && !pendValid &&
             toCnt != TO_W'(TIMEOUT_CYCLES))
      toCnt <= toCnt + TO_W'(1);
  end

  assign bus.msg  = msgQ;
  assign bus.ovf  = ovfQ;
  assign bus.noti = (state == NOTIFY);
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_speed_bcd_formatter.sv
// Directed bench for speed_bcd_formatter: latency, saturation, pending,
// peak-hold, timeout blanking and async reset.
module tb_speed_bcd_formatter;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nErrors;
  int   notiRises;
  logic notiQ;
  int   r0;

  speed_bcd_formatter_if bus ();

  speed_bcd_formatter #(
    .NOTI_CYCLES    (50),
    .TIMEOUT_CYCLES (100),
    .TO_W           (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    notiRises = 0;
    notiQ     = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.noti && !notiQ)
      notiRises = notiRises + 1;
    notiQ = bus.noti;
  end

  task automatic checkEq(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    bus.speed_bin   = v;
    bus.speed_valid = 1'b1;
    tick();
    bus.speed_valid = 1'b0;
  endtask

  task automatic sendSettle(input logic [7:0] v);
    send(v);
    repeat (65) tick();
  endtask

  initial begin
    nChecks         = 0;
    nErrors         = 0;
    rst_n           = 1'b0;
    bus.speed_bin   = '0;
    bus.speed_valid = 1'b0;
    bus.peak_mode   = 1'b0;
    bus.peak_clr    = 1'b0;
    repeat (3) tick();
    checkEq("rst_msg", bus.msg, 8'hFF);
    checkEq("rst_noti", bus.noti, 0);
    checkEq("rst_busy", bus.busy, 0);
    checkEq("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: latency and noti width
    send(8'd57);
    checkEq("t1_busy0", bus.busy, 1);
    repeat (8) tick();
    checkEq("t1_msg_k8", bus.msg, 8'hFF);
    checkEq("t1_noti_k8", bus.noti, 0);
    tick();
    checkEq("t1_msg", bus.msg, 8'h57);
    checkEq("t1_ovf", bus.ovf, 0);
    checkEq("t1_noti", bus.noti, 1);
    repeat (49) tick();
    checkEq("t1_noti_end", bus.noti, 1);
    checkEq("t1_busy_end", bus.busy, 1);
    tick();
    checkEq("t1_noti_fall", bus.noti, 0);
    checkEq("t1_busy_fall", bus.busy, 0);

    // 2: saturation
    send(8'd180);
    repeat (9) tick();
    checkEq("t2_sat_msg", bus.msg, 8'h99);
    checkEq("t2_sat_ovf", bus.ovf, 1);
    repeat (55) tick();
    send(8'd3);
    repeat (9) tick();
    checkEq("t2_msg3", bus.msg, 8'h03);
    checkEq("t2_ovf3", bus.ovf, 0);
    repeat (55) tick();

    // 3: pending newest wins
    r0 = notiRises;
    send(8'd12);
    repeat (2) tick();
    send(8'd20);
    tick();
    send(8'd45);
    repeat (150) tick();
    checkEq("t3_msg", bus.msg, 8'h45);
    checkEq("t3_rises", notiRises - r0, 2);
    checkEq("t3_busy", bus.busy, 0);

    // 4: peak hold
    r0 = notiRises;
    bus.peak_mode = 1'b1;
    sendSettle(8'd30);
    checkEq("t4_msg30", bus.msg, 8'h30);
    send(8'd25);
    checkEq("t4_drop_busy", bus.busy, 0);
    repeat (65) tick();
    sendSettle(8'd30);
    checkEq("t4_msg30b", bus.msg, 8'h30);
    sendSettle(8'd31);
    checkEq("t4_msg31", bus.msg, 8'h31);
    checkEq("t4_rises", notiRises - r0, 2);
    bus.peak_clr = 1'b1;
    send(8'd10);
    bus.peak_clr = 1'b0;
    repeat (65) tick();
    checkEq("t4_clr_msg", bus.msg, 8'h10);
    bus.peak_mode = 1'b0;

    // 5: timeout blank, exactly once
    r0 = notiRises;
    send(8'd150);
    repeat (9) tick();
    checkEq("t5_msg99", bus.msg, 8'h99);
    checkEq("t5_ovf1", bus.ovf, 1);
    repeat (149) tick();
    checkEq("t5_preblank", bus.msg, 8'h99);
    tick();
    checkEq("t5_blank", bus.msg, 8'hFF);
    checkEq("t5_blank_ovf", bus.ovf, 0);
    checkEq("t5_blank_noti", bus.noti, 1);
    repeat (350) tick();
    checkEq("t5_rises", notiRises - r0, 2);
    checkEq("t5_msg_hold", bus.msg, 8'hFF);

    // 6: async reset mid-conversion
    sendSettle(8'd64);
    checkEq("t6_msg64", bus.msg, 8'h64);
    send(8'd77);
    repeat (2) tick();
    send(8'd88);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checkEq("t6_msg", bus.msg, 8'hFF);
    checkEq("t6_noti", bus.noti, 0);
    checkEq("t6_busy", bus.busy, 0);
    checkEq("t6_ovf", bus.ovf, 0);
    tick();
    rst_n = 1'b1;
    r0 = notiRises;
    repeat (80) tick();
    checkEq("t6_rises", notiRises - r0, 0);
    checkEq("t6_msg_after", bus.msg, 8'hFF);
    checkEq("t6_busy_after", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
